// File: rtl/key_tone_player.sv
// Key-to-tone player: synchronised, debounced keys pick one C-major note; a square-wave tone and signed sample follow.
// Optional octave shift is enabled by defining KEY_TONE_OCTAVE_EN.
module key_tone_player #(
  parameter int                 NUM_KEYS        = 4,
  parameter int                 CLK_HZ          = 50_000_000,
  parameter int                 DEBOUNCE_CYCLES = 500_000,
  parameter bit                 KEY_ACTIVE_LOW  = 1'b1,
  parameter logic signed [15:0] AMPL            = 16'sd8192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                octave_up,
  input  logic                octave_down,
  output logic                note_valid,
  output logic [2:0]          note_idx,
  output logic [31:0]         half_period,
  output logic [1:0]          octave,
  output logic                tone_out,
  output logic signed [15:0]  sample
);

  // The debounce counter never exceeds DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] HP [8] = '{
    32'(CLK_HZ / (2 * 523)), 32'(CLK_HZ / (2 * 587)),
    32'(CLK_HZ / (2 * 659)), 32'(CLK_HZ / (2 * 698)),
    32'(CLK_HZ / (2 * 784)), 32'(CLK_HZ / (2 * 880)),
    32'(CLK_HZ / (2 * 988)), 32'(CLK_HZ / (2 * 1046))
  };

  logic [NUM_KEYS-1:0] key_norm;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] db;
  logic [CW-1:0]       db_cnt [NUM_KEYS];

  // Synchronisers reset to "not pressed" so a held key needs a full debounce after reset.
  assign key_norm = KEY_ACTIVE_LOW ? ~key : key;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_norm;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic       any_key;
  logic [2:0] sel_idx;

  always_comb begin
    any_key = 1'b0;
    sel_idx = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (db[i]) begin
        any_key = 1'b1;
        sel_idx = 3'(i);
      end
    end
  end

`ifdef KEY_TONE_OCTAVE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      octave <= 2'd0;
    end else if (octave_up && !octave_down && octave != 2'd2) begin
      octave <= octave + 2'd1;
    end else if (octave_down && !octave_up && octave != 2'd0) begin
      octave <= octave - 2'd1;
    end
  end
`else
  logic unused_octave_pulses;
  assign unused_octave_pulses = octave_up ^ octave_down;
  assign octave = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      note_valid  <= 1'b0;
      note_idx    <= 3'd0;
      half_period <= 32'd0;
    end else begin
      note_valid  <= any_key;
      if (any_key) note_idx <= sel_idx;
      half_period <= any_key ? (HP[sel_idx] >> octave) : 32'd0;
    end
  end

  // Any change of the sounding note (index, octave or validity) restarts the tone one cycle later.
  logic [31:0] cnt;
  logic        prev_valid;
  logic [2:0]  prev_idx;
  logic [1:0]  prev_oct;
  logic        restart;

  assign restart = (note_valid != prev_valid) || (note_idx != prev_idx) || (octave != prev_oct);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
      prev_idx   <= 3'd0;
      prev_oct   <= 2'd0;
      cnt        <= 32'd0;
      tone_out   <= 1'b0;
      sample     <= 16'sd0;
    end else begin
      prev_valid <= note_valid;
      prev_idx   <= note_idx;
      prev_oct   <= octave;
      if (!note_valid || restart) begin
        cnt      <= 32'd0;
        tone_out <= 1'b0;
      end else if (cnt == half_period - 32'd1) begin
        cnt      <= 32'd0;
        tone_out <= ~tone_out;
      end else begin
        cnt <= cnt + 32'd1;
      end
      sample <= note_valid ? (tone_out ? AMPL : -AMPL) : 16'sd0;
    end
  end

endmodule
